// File: rtl/prbs_pkg.sv
// Shared definitions for the 15-bit rotating pseudo-random byte generator and its checker.
// The generator and the checker both call these functions, so the sequence is defined in one place.
package prbs_pkg;

  localparam int PRBS_W = 15;
  localparam int BYTE_W = 8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // Byte produced by generator state s.
  function automatic logic [BYTE_W-1:0] prbs_exp(input logic [PRBS_W-1:0] s);
    return {s[0] ^ s[1], s[11:5]};
  endfunction

  // Next generator state: rotate left by one.
  function automatic logic [PRBS_W-1:0] prbs_adv(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[PRBS_W-1]};
  endfunction

endpackage

// File: rtl/prbs_rot15_checker_if.sv
// Byte stream, control and status bundle between a stream source/monitor and the checker.
interface prbs_rot15_checker_if #(
  parameter int ERR_CNT_W = 16
);
  import prbs_pkg::*;

  logic                 enable;
  logic [PRBS_W-1:0]    seed;
  logic                 in_valid;
  logic [BYTE_W-1:0]    in_data;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [3:0]           phase;

  modport master (
    output enable, seed, in_valid, in_data,
    input  locked, err_pulse, err_count, phase
  );

  modport slave (
    input  enable, seed, in_valid, in_data,
    output locked, err_pulse, err_count, phase
  );

endinterface

// File: rtl/prbs_rot15_checker_model.sv
// Local copy of the rotating generator: loads the seed, advances on request, otherwise holds.
module rot15_model
  import prbs_pkg::*;
(
  input  logic              clk,
  input  logic              load_i,
  input  logic [PRBS_W-1:0] seed_i,
  input  logic              adv_i,
  output logic [BYTE_W-1:0] exp_o
);

  logic [PRBS_W-1:0] s_q;
  logic [PRBS_W-1:0] s_d;

  // NOTE: combinational next-state gets a default first so no path leaves s_d unassigned (no latch).
  always_comb begin
    s_d = s_q;
    if (load_i) begin
      s_d = seed_i;
    end else if (adv_i) begin
      s_d = prbs_adv(s_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign exp_o = prbs_exp(s_q);

endmodule

// File: rtl/prbs_rot15_checker.sv
// Receive-side checker: aligns a local generator to the incoming byte stream, locks, then counts
// mismatching bytes. Search slips the local copy by one byte per mismatch until alignment is found.
module prbs_rot15_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_CNT_W  = 16
) (
  input logic                   clk,
  input logic                   rst,
  prbs_rot15_checker_if.slave   bus
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(LOSS_COUNT + 1);

  chk_state_t           state_q;
  logic [GOOD_W-1:0]    good_cnt_q;
  logic [BAD_W-1:0]     bad_cnt_q;
  logic                 locked_q;
  logic                 err_pulse_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [3:0]           phase_q;

  logic [BYTE_W-1:0]    exp_byte;
  logic                 accept;
  logic                 match;
  logic                 adv;

  assign accept = bus.enable && bus.in_valid;
  assign match  = (bus.in_data == exp_byte);
  // In SEARCH a mismatch holds the local copy, which is what slips the alignment by one byte.
  assign adv    = accept && ((state_q == LOCKED) || match);

  rot15_model u_model (
    .clk    (clk),
    .load_i (rst),
    .seed_i (bus.seed),
    .adv_i  (adv),
    .exp_o  (exp_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      phase_q     <= 4'd0;
    end else begin
      err_pulse_q <= 1'b0;
      if (accept) begin
        case (state_q)
          SEARCH: begin
            if (match) begin
              if (good_cnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                good_cnt_q <= '0;
              end else begin
                good_cnt_q <= good_cnt_q + 1'b1;
              end
            end else begin
              good_cnt_q <= '0;
              phase_q    <= (phase_q == 4'd14) ? 4'd0 : phase_q + 4'd1;
            end
          end
          LOCKED: begin
            if (match) begin
              bad_cnt_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (err_count_q != '1) begin
                err_count_q <= err_count_q + 1'b1;
              end
              if (bad_cnt_q == BAD_W'(LOSS_COUNT - 1)) begin
                state_q    <= SEARCH;
                locked_q   <= 1'b0;
                bad_cnt_q  <= '0;
                good_cnt_q <= '0;
              end else begin
                bad_cnt_q <= bad_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.phase     = phase_q;

endmodule
